// File: rtl/ebr_delay_line_if.sv
// Bundle of the delay line's data-path and control signals.
// The master side (pipeline controller) drives cen/len/clr/din.
// The slave side (the delay line) returns drop/busy/wrap.
interface ebr_delay_line_if #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 32
) ();

   localparam int LW = $clog2(STAGES + 1);

   logic             cen;
   logic [LW-1:0]    len;
   logic             clr;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] drop;
   logic             busy;
   logic             wrap;

   modport master (
      output cen,
      output len,
      output clr,
      output din,
      input  drop,
      input  busy,
      input  wrap
   );

   modport slave (
      input  cen,
      input  len,
      input  clr,
      input  din,
      output drop,
      output busy,
      output wrap
   );

endinterface

// File: rtl/ebr_delay_line.sv
// Block-RAM circular-buffer delay line with a run-time programmable length.
// It behaves like a len-stage shift register advanced by cen, built from one RAM
// with separate read and write pointers.
// After reset, on clr, or whenever the clamped length changes, the whole RAM is
// wiped to RSTVAL. During the wipe busy is high and cen/din are ignored.
// wrap marks slot 0 of every frame so downstream logic can stay in sync.
module ebr_delay_line #(
   parameter int               WIDTH  = 5,
   parameter int               STAGES = 32,
   parameter logic [WIDTH-1:0] RSTVAL = '0
) (
   input logic              clk,
   input logic              rst,
   ebr_delay_line_if.slave  bus
);

   localparam int AW    = $clog2(STAGES);
   localparam int DEPTH = 2 ** AW;
   localparam int LW    = $clog2(STAGES + 1);

   localparam logic [LW-1:0] LEN_MIN   = LW'(2);
   localparam logic [LW-1:0] LEN_MAX   = LW'(STAGES);
   localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
   localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

   typedef enum logic {
      WIPE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nx;

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wipe_addr;
   logic [LW-1:0]    len_r;
   logic [LW-1:0]    len_c;
   logic [WIDTH-1:0] drop_r;

   logic             wipe_req;
   logic             shift;
   logic             wr_last;
   logic             rd_last;

   logic [WIDTH-1:0] mem [DEPTH];

   // Clamp the requested length into the supported range [2, STAGES].
   // Below 2 the read and write pointers would collide on the same address.
   always_comb begin
      len_c = bus.len;
      if (bus.len < LEN_MIN) begin
         len_c = LEN_MIN;
      end else if (bus.len > LEN_MAX) begin
         len_c = LEN_MAX;
      end
   end

   // Decode a wipe request, a real shift, and the pointer wrap points.
   // A wipe request wins over cen, so the edge that starts a wipe never shifts.
   always_comb begin
      wipe_req = (state == RUN) && (bus.clr || (len_c != len_r));
      shift    = (state == RUN) && bus.cen && !wipe_req;
      wr_last  = (LW'(wr_ptr) == (len_r - LW'(1)));
      rd_last  = (LW'(rd_ptr) == (len_r - LW'(1)));
   end

   // State register; reset always restarts from a full wipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= WIPE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic.
   // The wipe ends on the edge that writes the last RAM word.
   // In RUN, a clear request or a length change sends the block back to WIPE.
   always_comb begin
      state_nx = state;
      unique case (state)
         WIPE: begin
            if (wipe_addr == ADDR_LAST) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            if (wipe_req) begin
               state_nx = WIPE;
            end
         end
         default: state_nx = WIPE;
      endcase
   end

   // Output decode.
   // busy covers the whole wipe. wrap flags slot 0 of each frame while running.
   always_comb begin
      bus.busy = (state == WIPE);
      bus.wrap = (state == RUN) && (wr_ptr == '0);
      bus.drop = drop_r;
   end

   // Pointer, length and output registers.
   // The read pointer always sits one slot ahead of the write pointer (mod len_r),
   // which gives exactly len_r-1 edges of RAM storage plus the output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wipe_addr <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= ADDR_ONE;
         len_r     <= LEN_MAX;
         drop_r    <= RSTVAL;
      end else begin
         unique case (state)
            WIPE: begin
               wipe_addr <= (wipe_addr == ADDR_LAST) ? '0 : (wipe_addr + ADDR_ONE);
               len_r     <= len_c;
               drop_r    <= RSTVAL;
               wr_ptr    <= '0;
               rd_ptr    <= ADDR_ONE;
            end
            RUN: begin
               if (wipe_req) begin
                  wipe_addr <= '0;
                  drop_r    <= RSTVAL;
                  wr_ptr    <= '0;
                  rd_ptr    <= ADDR_ONE;
               end else if (shift) begin
                  drop_r <= mem[rd_ptr];
                  wr_ptr <= wr_last ? '0 : (wr_ptr + ADDR_ONE);
                  rd_ptr <= rd_last ? '0 : (rd_ptr + ADDR_ONE);
               end
            end
            default: begin
               wipe_addr <= '0;
               drop_r    <= RSTVAL;
               wr_ptr    <= '0;
               rd_ptr    <= ADDR_ONE;
            end
         endcase
      end
   end

   // RAM write port; it is fed by the wipe sweep or by the shifting data.
   // There is no reset so that it maps onto block RAM.
   // Pre-reset contents are never observable because the wipe always runs first.
   always_ff @(posedge clk) begin
      if (state == WIPE) begin
         mem[wipe_addr] <= RSTVAL;
      end else if (shift) begin
         mem[wr_ptr] <= bus.din;
      end
   end

endmodule

// File: tb/tb_ebr_delay_line.sv
// Self-checking bench for ebr_delay_line (WIDTH=5, STAGES=32, RSTVAL=5'h15).
// A hand-computed vector table covers a short len=3 run.
// Longer sequences are checked against a queue-based shift-register model.
module tb_ebr_delay_line;

   localparam int               WIDTH  = 5;
   localparam int               STAGES = 32;
   localparam logic [WIDTH-1:0] R      = 5'h15;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int tests = 0;
   int fails = 0;

   logic [4:0] q[$];
   logic [4:0] exp_drop;
   int         cnt;
   int         mlen;

   typedef struct {
      logic       cen;
      logic       clr;
      logic [5:0] len;
      logic [4:0] din;
      logic [4:0] exp_drop;
      logic       exp_busy;
      logic       exp_wrap;
   } vec_t;

   vec_t tbl[12];

   ebr_delay_line_if #(.WIDTH(WIDTH), .STAGES(STAGES)) bus ();

   ebr_delay_line #(.WIDTH(WIDTH), .STAGES(STAGES), .RSTVAL(R)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock with a 10 ns period.
   always #5 clk = ~clk;

   // Watchdog: stop the run if it ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic c, input logic cl, input logic [5:0] l,
                                input logic [4:0] d);
      bus.cen = c;
      bus.clr = cl;
      bus.len = l;
      bus.din = d;
   endtask

   task automatic checkOutput(input string name, input logic [4:0] ed, input logic eb,
                              input logic ew);
      tests++;
      if (bus.drop !== ed || bus.busy !== eb || bus.wrap !== ew) begin
         fails++;
         $display("[TB] FAIL %s: got drop=%h busy=%b wrap=%b, required drop=%h busy=%b wrap=%b",
                  name, bus.drop, bus.busy, bus.wrap, ed, eb, ew);
      end
   endtask

   task automatic checkValue(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // The model is a FIFO preloaded with l-1 RSTVAL entries; each cen edge pushes din and pops drop.
   task automatic resetModel(input int l);
      q.delete();
      for (int i = 0; i < l - 1; i++) q.push_back(R);
      exp_drop = R;
      cnt      = 0;
      mlen     = l;
   endtask

   task automatic modelEdge(input string name, input logic c, input logic [5:0] l,
                            input logic [4:0] d);
      applyStimulus(c, 1'b0, l, d);
      tick();
      if (c) begin
         q.push_back(d);
         exp_drop = q.pop_front();
         cnt      = (cnt + 1) % mlen;
      end
      checkOutput(name, exp_drop, 1'b0, (cnt == 0));
   endtask

   // Count edges until busy falls (bounded), optionally pulsing clr at edge clr_at.
   task automatic wipeCheck(input string name, input int clr_at);
      int n;
      bit bad;
      n   = 0;
      bad = 1'b0;
      while (bus.busy === 1'b1 && n < 100) begin
         bus.clr = (n == clr_at);
         tick();
         n++;
         if (bus.busy === 1'b1 && bus.drop !== R) bad = 1'b1;
      end
      bus.clr = 1'b0;
      checkValue({name, " busy edges"}, n, STAGES);
      checkValue({name, " drop during wipe"}, int'(bad), 0);
      checkOutput({name, " exit"}, R, 1'b0, 1'b1);
   endtask

   task automatic enterWipe(input string name, input logic cl, input logic [5:0] l);
      applyStimulus(1'b1, cl, l, 5'h0A);
      tick();
      bus.clr = 1'b0;
      checkOutput({name, " enter wipe"}, R, 1'b1, 1'b0);
   endtask

   initial begin
      // Hand-computed len=3 run (drop lags din by 2 cen edges), ending in a clr.
      tbl[0]  = '{1'b1, 1'b0, 6'd3, 5'd1,  5'h15, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 6'd3, 5'd2,  5'h15, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 6'd3, 5'd3,  5'h01, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 6'd3, 5'd9,  5'h01, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 6'd3, 5'd4,  5'h02, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 6'd3, 5'd5,  5'h03, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 6'd3, 5'd7,  5'h03, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 6'd3, 5'd6,  5'h04, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 6'd3, 5'h1F, 5'h05, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 6'd3, 5'd0,  5'h06, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 6'd3, 5'd0,  5'h1F, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 1'b1, 6'd3, 5'd9,  5'h15, 1'b1, 1'b0};

      // Reset and the initial wipe.
      applyStimulus(1'b0, 1'b0, 6'd32, 5'd0);
      #1 rst = 1'b1;
      #1 checkOutput("async reset", R, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("reset hold", R, 1'b1, 1'b0);
      rst = 1'b0;
      wipeCheck("reset wipe", -1);

      // len=32 with continuous cen; the wrap period is 32.
      resetModel(32);
      for (int k = 0; k < 70; k++) modelEdge("t1 len32", 1'b1, 6'd32, 5'(k));

      // cen pattern 1,0,0,1: only cen edges count.
      for (int k = 0; k < 80; k++)
         modelEdge("t2 cen pattern", ((k % 4) == 0) || ((k % 4) == 3), 6'd32, 5'(k + 7));

      // Switch the length to 5.
      enterWipe("t3 len5", 1'b0, 6'd5);
      wipeCheck("t3 wipe", -1);
      resetModel(5);
      for (int k = 0; k < 20; k++) modelEdge("t3 len5", 1'b1, 6'd5, 5'(k + 3));

      // len=0 clamps to 2; len=1 has the same clamp, so there is no wipe.
      enterWipe("t4 len0", 1'b0, 6'd0);
      wipeCheck("t4 wipe len0", -1);
      resetModel(2);
      for (int k = 0; k < 6; k++) modelEdge("t4 len0", 1'b1, 6'd0, 5'(k + 1));
      for (int k = 0; k < 6; k++) modelEdge("t4 len1", 1'b1, 6'd1, 5'(k + 11));

      // len=40 clamps to 32; 33 has the same clamp, so there is no wipe.
      enterWipe("t4 len40", 1'b0, 6'd40);
      wipeCheck("t4 wipe len40", -1);
      resetModel(32);
      for (int k = 0; k < 40; k++) modelEdge("t4 len40", 1'b1, 6'd40, 5'(k));
      for (int k = 0; k < 5; k++) modelEdge("t4 len33", 1'b1, 6'd33, 5'(k + 2));

      // Table-driven len=3 run, then a clr with a second clr during the wipe.
      enterWipe("t6 len3", 1'b0, 6'd3);
      wipeCheck("t6 wipe len3", -1);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(tbl[i].cen, tbl[i].clr, tbl[i].len, tbl[i].din);
         tick();
         checkOutput($sformatf("table vec %0d", i), tbl[i].exp_drop, tbl[i].exp_busy,
                     tbl[i].exp_wrap);
      end
      bus.clr = 1'b0;
      wipeCheck("t6 clr wipe", 10);
      resetModel(3);
      for (int k = 0; k < 6; k++) modelEdge("t6 after clr", 1'b1, 6'd3, 5'(k + 20));

      // Fill with 5'h1F, then reset mid-run and again mid-wipe.
      enterWipe("t5 len32", 1'b0, 6'd32);
      wipeCheck("t5 wipe", -1);
      resetModel(32);
      for (int k = 0; k < 40; k++) modelEdge("t5 fill", 1'b1, 6'd32, 5'h1F);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 checkOutput("t5 rst mid-run", R, 1'b1, 1'b0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      checkOutput("t5 mid-wipe", R, 1'b1, 1'b0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 checkOutput("t5 rst mid-wipe", R, 1'b1, 1'b0);
      tick();
      rst = 1'b0;
      wipeCheck("t5 rewipe", -1);
      resetModel(32);
      for (int k = 0; k < 40; k++) modelEdge("t5 no stale", 1'b1, 6'd32, 5'(k % 16));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
